div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
- REQ-001: Parameter WIDTH, default 32, sets the operand and result width in bits.
- REQ-002: Parameter ITERS, default 32, sets the number of restoring iterations and SHALL equal WIDTH.
- REQ-003: clk  input  1  system clock; all state changes on the rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: start  input  1  request a division; sampled only in IDLE or DONE.
- REQ-006: is_signed  input  1  1 = DIV semantics, 0 = DIVU semantics; captured with start.
- REQ-007: dividend  input  WIDTH  numerator (rs); captured with start.
- REQ-008: divisor  input  WIDTH  denominator (rt); captured with start.
- REQ-009: abort  input  1  exception flush; cancels an operation in flight.
- REQ-010: busy  output  1  operation in progress; the datapath uses it as a PC/writeback stall.
- REQ-011: done  output  1  one-cycle pulse; results are valid.
- REQ-012: quotient  output  WIDTH  LO value; held until the next completion.
- REQ-013: remainder  output  WIDTH  HI value; held until the next completion.

Function
- REQ-014: The FSM SHALL have the states IDLE, PREP, RUN, FIX and DONE.
- REQ-015: In IDLE or DONE with start=1, the block SHALL capture is_signed, dividend and divisor and go to PREP; otherwise DONE goes to IDLE and IDLE holds.
- REQ-016: PREP SHALL form operand magnitudes (two's-complement abs when is_signed), record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign), clear the iteration counter, and go to RUN.
- REQ-017: RUN SHALL perform one restoring shift-subtract step per cycle for exactly ITERS cycles, then go to FIX.
- REQ-018: FIX SHALL apply sign correction, register quotient and remainder, and go to DONE.
- REQ-019: Completion latency SHALL be 34 cycles: done is high in the cycle after the 34th edge following the edge that accepted start.
- REQ-020: busy SHALL be a registered decode of state in {PREP, RUN, FIX}; done SHALL equal state==DONE.
- REQ-021: start while busy SHALL be ignored and have no side effects.
- REQ-022: Division by zero SHALL be detected in PREP and SHALL go directly to DONE with quotient = all ones and remainder = dividend; done is high 2 cycles after start.
- REQ-023: Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
- REQ-024: The remainder sign SHALL equal the dividend sign, and abs(remainder) < abs(divisor).
- REQ-025: abort in PREP, RUN or FIX SHALL return the FSM to IDLE on the next edge, with no done pulse and quotient/remainder unchanged.
- REQ-026: abort in IDLE or DONE SHALL be ignored.
- REQ-027: abort and start asserted together in IDLE or DONE SHALL be resolved as start.
- REQ-028: The iteration counter SHALL be ceil(log2(ITERS))+1 bits wide and SHALL never wrap during RUN.

Reset
- REQ-029: rst=1 at any edge, including mid-RUN, SHALL force IDLE and clear busy, done, quotient, remainder, the counter and all internal registers to 0.
- REQ-030: rst SHALL take priority over start and abort.

Structure
- REQ-031: FSM state encodings (3-bit) and the divide-by-zero result constants SHALL live in the shared CPU definitions file used by the controller and the ALU.
- REQ-032: A single combinational sub-module, div_step, SHALL implement one shift-subtract step (partial remainder and quotient in; updated partial remainder, quotient bit and shifted quotient out).
- REQ-033: div_seq SHALL hold only the FSM, the counter and the operand/result registers.

Verification
- REQ-034: Unsigned 100 / 7 -> quotient 0x0000000E, remainder 0x00000002; busy high for exactly 34 cycles; done high for exactly 1 cycle.
- REQ-035: Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFF9 / 2 -> quotient 0x7FFFFFFC, remainder 0x00000001.
- REQ-036: 0x12345678 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 0x12345678; done 2 cycles after start.
- REQ-037: Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000; done at 34 cycles.
- REQ-038: Complete 100/7, then start 50/3 and re-pulse start with 9/9 at cycle 10 (ignored), then abort at cycle 20 -> busy low at the next edge, no done pulse, quotient/remainder still 14/2.
- REQ-039: rst asserted at RUN iteration 15 -> the next cycle shows IDLE and all outputs 0; a subsequent 100/7 completes correctly in 34 cycles.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared CPU divider definitions: FSM state encodings and divide-by-zero result constants.
// Imported by the divider controller and the ALU.
package div_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    // Divide by zero: the quotient is filled with this bit (all ones);
    // the remainder passes the raw dividend through.
    localparam logic DIV0_QUO_BIT       = 1'b1;
    localparam logic DIV0_REM_DIVIDEND  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of an unsigned divider (purely combinational).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra top bit of diff acts as the borrow: set means "restore".
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: IDLE -> PREP -> RUN x ITERS -> FIX -> DONE.
// Holds only the FSM, the iteration counter and the operand/result registers.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(ITERS) + 1;

    div_state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             sgn_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] part_quo;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             step_bit;
    logic             div_zero;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign div_zero = (dvs_r == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (part_rem),
        .quo_in  (part_quo),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .quo_out (step_quo),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_PREP) || (state_nxt == ST_RUN) || (state_nxt == ST_FIX);
        end
    end

    // Start wins over abort in IDLE/DONE; abort flushes PREP/RUN/FIX.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_PREP;
            ST_PREP: begin
                if (abort)         state_nxt = ST_IDLE;
                else if (div_zero) state_nxt = ST_DONE;
                else               state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                           state_nxt = ST_IDLE;
                else if (cnt == CNT_W'(ITERS - 1))   state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = abort ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = start ? ST_PREP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sgn_r     <= 1'b0;
            dvd_r     <= '0;
            dvs_r     <= '0;
            dvs_mag   <= '0;
            part_rem  <= '0;
            part_quo  <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sgn_r <= is_signed;
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                    end
                end
                ST_PREP: begin
                    if (!abort) begin
                        q_neg    <= sgn_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
                        r_neg    <= sgn_r & dvd_r[WIDTH-1];
                        part_quo <= magnitude(dvd_r, sgn_r);
                        dvs_mag  <= magnitude(dvs_r, sgn_r);
                        part_rem <= '0;
                        cnt      <= '0;
                        if (div_zero) begin
                            quotient  <= {WIDTH{DIV0_QUO_BIT}};
                            remainder <= DIV0_REM_DIVIDEND ? dvd_r : '0;
                        end
                    end
                end
                ST_RUN: begin
                    part_rem <= step_rem;
                    part_quo <= step_quo;
                    cnt      <= cnt + 1'b1;
                end
                ST_FIX: begin
                    if (!abort) begin
                        quotient  <= apply_sign(part_quo, q_neg);
                        remainder <= apply_sign(part_rem, r_neg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
